mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Sole owner of the byte-wide unified RAM port.
- Shares that port between three requesters:
  - instruction fetch: 32-bit reads
  - load buffer: 1/2/4-byte reads with extension
  - store commit: 1/2/4-byte writes
- Serialises each request into byte transactions and reassembles read data into one response pulse.
- Sits between the core-side memory clients and the top-level RAM interface.

## Interface
Parameters:
- none; inst-type codes and widths (`INST_TYPE_WIDTH`, `ROB_WIDTH`, `LB`/`LH`/`LW`/`LBU`/`LHU`/`SB`/`SH`/`SW`) come from define.vh.

Ports:
- clk_in  input  1  system clock; all state changes on posedge.
- rst_in  input  1  synchronous, active-high reset.
- rdy_in  input  1  global enable; low freezes all state.
- rob_flush_in  input  1  mispredict flush.
- if_en_in  input  1  fetch request.
- if_addr_in  input  32  fetch address.
- if_rdy_out  output  1  fetch may issue.
- if_data_en_out  output  1  one-cycle fetch response pulse.
- if_data_out  output  32  fetched word.
- lbuf_en_in  input  1  load request.
- lbuf_A_in  input  32  load byte address.
- lbuf_dest_in  input  `ROB_WIDTH`  load ROB tag.
- lbuf_inst_type_in  input  `INST_TYPE_WIDTH`  LB/LH/LW/LBU/LHU.
- lbuf_rdy_out  output  1  load may issue.
- lbuf_data_en_out  output  1  one-cycle load response pulse.
- lbuf_data_out  output  32  extended load value.
- st_en_in  input  1  committed store request.
- st_addr_in  input  32  store address.
- st_data_in  input  32  store data (low bytes used).
- st_inst_type_in  input  `INST_TYPE_WIDTH`  SB/SH/SW.
- st_rdy_out  output  1  store may issue.
- st_done_out  output  1  one-cycle store-complete pulse.
- mem_din_in  input  8  RAM read byte; valid one cycle after its address.
- mem_dout_out  output  8  RAM write byte.
- mem_a_out  output  32  RAM byte address.
- mem_wr_out  output  1  1 = write, 0 = read.

## Operation
- States:
  - IDLE
  - READ: fetch or load in progress
  - WRITE
  - DONE: response cycle
- Registers:
  - owner: IF or LBUF
  - base address
  - byte count N: 1/2/4
  - index k: 3 bits
  - 32-bit assembly register
  - type
- Ready outputs:
  - if_rdy_out, lbuf_rdy_out and st_rdy_out are each (state == IDLE).
  - A request is accepted only in IDLE with its en high.
- Grant priority in IDLE: store > load > fetch.
  - Store first: a committed store must never stall ROB retirement.
  - Load before fetch: loads block the ROB head.
- READ:
  - Cycles k = 0..N-1: mem_a_out = base+k, mem_wr_out = 0.
  - Cycles k = 1..N: byte (k-1) is captured from mem_din_in into assembly bits [8(k-1)+7 : 8(k-1)]. Little-endian.
  - After the capture at k = N: go to DONE.
- DONE:
  - Assert the owner's data_en for exactly one cycle, then return to IDLE.
  - Load value is extended per type:
    - LB/LH sign-extend
    - LBU/LHU zero-extend
    - LW unchanged
  - Fetch is always N = 4, unextended.
- WRITE:
  - Cycles k = 0..N-1: mem_a_out = base+k, mem_dout_out = st_data[8k+7:8k], mem_wr_out = 1.
  - In the cycle after the last write: st_done_out = 1, mem_wr_out = 0, state goes to IDLE.
- Outside WRITE: mem_wr_out = 0 and mem_dout_out = 0.
- Flush (rob_flush_in = 1, rdy_in = 1):
  - In READ or DONE: abort to IDLE next cycle with no data_en.
  - In WRITE: ignored; the store completes normally.
  - In IDLE: fetch and load requests are not accepted; a store request is accepted.
- rdy_in = 0: all registers hold; mem_wr_out forced 0.
- Reset:
  - state = IDLE
  - every response pulse = 0
  - mem_wr_out = 0, mem_a_out = 0, mem_dout_out = 0
  - all data outputs = 0

## Timing
- Grant is taken at the IDLE edge; the first RAM address is driven the next cycle.
- Read latency from the accepting edge to data_en high:
  - N+2 cycles
  - LB: 3, LH: 4, LW and fetch: 6
- Store latency from the accepting edge to st_done_out high: N+1 cycles.
- Back-to-back transactions cost at least one IDLE cycle between them.
- Simultaneous requests:
  - Losers are not latched.
  - Requesters must hold en and operands until they see rdy high together with their own grant, i.e. until their response pulse.
- Addresses increment without alignment checks; base+k wraps modulo 2^32.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Load and fetch alternate priority.
  - After a load grant, fetch wins the next load/fetch tie; after a fetch grant, load wins.
  - Store keeps absolute priority.
  - The priority bit resets to "load first".
- `MEM_ARB_RR_EN` undefined: fixed store > load > fetch.

## Test plan
- **Reset:** rst_in high 2 cycles with requests active -> all outputs 0, state IDLE, no grant during reset.
- **LB:** LB at 0x100 with RAM[0x100] = 0x80 -> lbuf_data_en_out on cycle 3, lbuf_data_out = 0xFFFFFF80.
- **LBU:** LBU at the same address -> 0x00000080.
- **Contention:** fetch at 0x0 (RAM 0x13,0x05,0x10,0x00) and SW at 0x200 of 0xDEADBEEF in the same cycle:
  - bytes EF, BE, AD, DE are written to 0x200..0x203 first, with st_done_out on cycle 5;
  - the fetch then returns 0x00100513.
- **Flush:** rob_flush_in on cycle 2 of an LW -> no lbuf_data_en_out, state IDLE on cycle 3, next request accepted.
  - Flush during an SH -> both bytes are written and st_done_out still pulses.
- **rdy_in stall:** rdy_in low for 3 cycles mid-LW -> mem_a_out holds and mem_wr_out stays 0; the result is correct, delivered 3 cycles late.
- **Round-robin:** with `MEM_ARB_RR_EN`, fetch and load held continuously -> grants alternate load, fetch, load.
  - Without the macro, load wins every tie.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: sole owner of the byte-wide unified RAM port. It serialises instruction fetch,
// load buffer and store commit requests into byte transactions and reassembles read bytes
// into a single response pulse.
// Optional feature macro MEM_ARB_RR_EN: load and fetch alternate priority on ties. When it is
// undefined the grant order is fixed at store > load > fetch.
// Inst-type codes normally come from define.vh; local defaults apply when it is not included.

`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 4
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif
`ifndef LB
`define LB  4'd0
`endif
`ifndef LH
`define LH  4'd1
`endif
`ifndef LW
`define LW  4'd2
`endif
`ifndef LBU
`define LBU 4'd3
`endif
`ifndef LHU
`define LHU 4'd4
`endif
`ifndef SB
`define SB  4'd5
`endif
`ifndef SH
`define SH  4'd6
`endif
`ifndef SW
`define SW  4'd7
`endif

module mem_arbiter (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        rob_flush_in,
  input  logic                        if_en_in,
  input  logic [31:0]                 if_addr_in,
  output logic                        if_rdy_out,
  output logic                        if_data_en_out,
  output logic [31:0]                 if_data_out,
  input  logic                        lbuf_en_in,
  input  logic [31:0]                 lbuf_A_in,
  input  logic [`ROB_WIDTH-1:0]       lbuf_dest_in,
  input  logic [`INST_TYPE_WIDTH-1:0] lbuf_inst_type_in,
  output logic                        lbuf_rdy_out,
  output logic                        lbuf_data_en_out,
  output logic [31:0]                 lbuf_data_out,
  input  logic                        st_en_in,
  input  logic [31:0]                 st_addr_in,
  input  logic [31:0]                 st_data_in,
  input  logic [`INST_TYPE_WIDTH-1:0] st_inst_type_in,
  output logic                        st_rdy_out,
  output logic                        st_done_out,
  input  logic [7:0]                  mem_din_in,
  output logic [7:0]                  mem_dout_out,
  output logic [31:0]                 mem_a_out,
  output logic                        mem_wr_out
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e                      state_q, state_d;
  logic                        owner_q, owner_d;  // 1 = load buffer, 0 = fetch
  logic [31:0]                 base_q, base_d;
  logic [2:0]                  n_q, n_d;
  logic [2:0]                  k_q, k_d;
  logic [31:0]                 data_q, data_d;    // read assembly, or store data
  logic [`INST_TYPE_WIDTH-1:0] type_q, type_d;

  logic        ld_req, if_req, ld_first;
  logic        grant_st, grant_ld, grant_if;
  logic        rd_pulse;
  logic [31:0] ld_ext;

  // The ROB tag is tracked by the load buffer itself; the arbiter never needs it.
  logic unused_dest;
  assign unused_dest = ^lbuf_dest_in;

  function automatic logic [2:0] size_of(input logic [`INST_TYPE_WIDTH-1:0] t);
    case (t)
      `LB, `LBU, `SB: size_of = 3'd1;
      `LH, `LHU, `SH: size_of = 3'd2;
      default:        size_of = 3'd4;
    endcase
  endfunction

  // A flush kills speculative fetch/load requests but never a committed store.
  assign ld_req   = lbuf_en_in && !rob_flush_in;
  assign if_req   = if_en_in && !rob_flush_in;
  assign grant_st = (state_q == StIdle) && st_en_in;
  assign grant_ld = (state_q == StIdle) && !st_en_in && ld_req && (ld_first || !if_req);
  assign grant_if = (state_q == StIdle) && !st_en_in && if_req && !grant_ld;

`ifdef MEM_ARB_RR_EN
  logic rr_q, rr_d;  // 1 = fetch wins the next load/fetch tie

  assign ld_first = !rr_q;

  // Flip tie priority towards whichever of load/fetch was not just granted.
  always_comb begin
    rr_d = rr_q;
    if (rdy_in && grant_ld) begin
      rr_d = 1'b1;
    end else if (rdy_in && grant_if) begin
      rr_d = 1'b0;
    end
  end

  // Round-robin priority register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  assign ld_first = 1'b1;
`endif

  // Next-state and datapath updates; rdy_in low leaves every _d at its _q.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    n_d     = n_q;
    k_d     = k_q;
    data_d  = data_q;
    type_d  = type_q;
    if (rdy_in) begin
      case (state_q)
        StIdle: begin
          if (grant_st) begin
            state_d = StWrite;
            base_d  = st_addr_in;
            n_d     = size_of(st_inst_type_in);
            k_d     = 3'd0;
            data_d  = st_data_in;
            type_d  = st_inst_type_in;
          end else if (grant_ld) begin
            state_d = StRead;
            owner_d = 1'b1;
            base_d  = lbuf_A_in;
            n_d     = size_of(lbuf_inst_type_in);
            k_d     = 3'd0;
            data_d  = 32'd0;
            type_d  = lbuf_inst_type_in;
          end else if (grant_if) begin
            state_d = StRead;
            owner_d = 1'b0;
            base_d  = if_addr_in;
            n_d     = 3'd4;
            k_d     = 3'd0;
            data_d  = 32'd0;
            type_d  = `LW;
          end
        end
        StRead: begin
          if (rob_flush_in) begin
            state_d = StIdle;
          end else begin
            // Byte k-1 arrives one cycle after its address; k=4 wraps k[1:0]-1 to lane 3.
            if (k_q != 3'd0) begin
              data_d[{k_q[1:0] - 2'd1, 3'b000} +: 8] = mem_din_in;
            end
            if (k_q == n_q) begin
              state_d = StDone;
            end else begin
              k_d = k_q + 3'd1;
            end
          end
        end
        StWrite: begin
          if (k_q == n_q) begin
            state_d = StIdle;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Arbiter state register with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      base_q  <= 32'd0;
      n_q     <= 3'd0;
      k_q     <= 3'd0;
      data_q  <= 32'd0;
      type_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      n_q     <= n_d;
      k_q     <= k_d;
      data_q  <= data_d;
      type_q  <= type_d;
    end
  end

  // Load result extension by access type.
  always_comb begin
    ld_ext = data_q;
    case (type_q)
      `LB:     ld_ext = {{24{data_q[7]}}, data_q[7:0]};
      `LH:     ld_ext = {{16{data_q[15]}}, data_q[15:0]};
      `LBU:    ld_ext = {24'd0, data_q[7:0]};
      `LHU:    ld_ext = {16'd0, data_q[15:0]};
      default: ld_ext = data_q;
    endcase
  end

  assign if_rdy_out   = (state_q == StIdle);
  assign lbuf_rdy_out = (state_q == StIdle);
  assign st_rdy_out   = (state_q == StIdle);

  // Response pulses only count in enabled cycles so each is seen exactly once.
  assign rd_pulse         = (state_q == StDone) && rdy_in && !rob_flush_in;
  assign if_data_en_out   = rd_pulse && !owner_q;
  assign lbuf_data_en_out = rd_pulse && owner_q;
  assign if_data_out      = if_data_en_out ? data_q : 32'd0;
  assign lbuf_data_out    = lbuf_data_en_out ? ld_ext : 32'd0;
  assign st_done_out      = (state_q == StWrite) && (k_q == n_q) && rdy_in;

  assign mem_a_out    = ((state_q == StRead) || (state_q == StWrite)) ?
                        base_q + {29'd0, k_q} : 32'd0;
  assign mem_wr_out   = (state_q == StWrite) && (k_q != n_q) && rdy_in;
  assign mem_dout_out = mem_wr_out ? data_q[{k_q[1:0], 3'b000} +: 8] : 8'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a byte RAM model.
// Responses (kind, value, cycle) are queued at issue; a monitor pops them on each pulse.

`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 4
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif
`ifndef LB
`define LB  4'd0
`endif
`ifndef LH
`define LH  4'd1
`endif
`ifndef LW
`define LW  4'd2
`endif
`ifndef LBU
`define LBU 4'd3
`endif
`ifndef LHU
`define LHU 4'd4
`endif
`ifndef SB
`define SB  4'd5
`endif
`ifndef SH
`define SH  4'd6
`endif
`ifndef SW
`define SW  4'd7
`endif

module tb_mem_arbiter;

  logic                        clk;
  logic                        rst_in, rdy_in, rob_flush_in;
  logic                        if_en_in, if_rdy_out, if_data_en_out;
  logic [31:0]                 if_addr_in, if_data_out;
  logic                        lbuf_en_in, lbuf_rdy_out, lbuf_data_en_out;
  logic [31:0]                 lbuf_A_in, lbuf_data_out;
  logic [`ROB_WIDTH-1:0]       lbuf_dest_in;
  logic [`INST_TYPE_WIDTH-1:0] lbuf_inst_type_in, st_inst_type_in;
  logic                        st_en_in, st_rdy_out, st_done_out;
  logic [31:0]                 st_addr_in, st_data_in;
  logic [7:0]                  mem_din_in, mem_dout_out;
  logic [31:0]                 mem_a_out;
  logic                        mem_wr_out;

  mem_arbiter dut (
    .clk_in            (clk),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .rob_flush_in      (rob_flush_in),
    .if_en_in          (if_en_in),
    .if_addr_in        (if_addr_in),
    .if_rdy_out        (if_rdy_out),
    .if_data_en_out    (if_data_en_out),
    .if_data_out       (if_data_out),
    .lbuf_en_in        (lbuf_en_in),
    .lbuf_A_in         (lbuf_A_in),
    .lbuf_dest_in      (lbuf_dest_in),
    .lbuf_inst_type_in (lbuf_inst_type_in),
    .lbuf_rdy_out      (lbuf_rdy_out),
    .lbuf_data_en_out  (lbuf_data_en_out),
    .lbuf_data_out     (lbuf_data_out),
    .st_en_in          (st_en_in),
    .st_addr_in        (st_addr_in),
    .st_data_in        (st_data_in),
    .st_inst_type_in   (st_inst_type_in),
    .st_rdy_out        (st_rdy_out),
    .st_done_out       (st_done_out),
    .mem_din_in        (mem_din_in),
    .mem_dout_out      (mem_dout_out),
    .mem_a_out         (mem_a_out),
    .mem_wr_out        (mem_wr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered read, one cycle latency; frozen together with the system by rdy_in.
  logic [7:0] ram [0:1023];
  always @(posedge clk) begin
    if (rst_in) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
      ram[10'h000] <= 8'h13;
      ram[10'h001] <= 8'h05;
      ram[10'h002] <= 8'h10;
      ram[10'h003] <= 8'h00;
      ram[10'h100] <= 8'h80;
      ram[10'h101] <= 8'hF0;
      ram[10'h300] <= 8'h11;
      ram[10'h301] <= 8'h22;
      ram[10'h302] <= 8'h33;
      ram[10'h303] <= 8'h44;
      ram[10'h3FF] <= 8'h5A;
      mem_din_in   <= 8'h00;
    end else if (rdy_in) begin
      if (mem_wr_out) ram[mem_a_out[9:0]] <= mem_dout_out;
      mem_din_in <= ram[mem_a_out[9:0]];
    end
  end

  typedef struct {
    int          kind;  // 0 fetch, 1 load, 2 store done
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input int kind, input logic [31:0] d, input int c);
    exp_t e;
    e.kind = kind;
    e.data = d;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input int kind, input logic [31:0] d);
    exp_t e;
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_pulse: kind %0d data 0x%08h at cycle %0d, expected no pulse",
               kind, d, cyc);
    end else begin
      e = sb_q.pop_front();
      chk($sformatf("rsp_kind@%0d", cyc), 32'(kind), 32'(e.kind));
      chk($sformatf("rsp_data@%0d", cyc), d, e.data);
      chk($sformatf("rsp_cycle(kind %0d)", e.kind), 32'(cyc), 32'(e.cyc));
    end
  endtask

  // Monitor: compares every response pulse against the scoreboard head.
  always begin
    @(negedge clk);
    #1;
    if (!rst_in) begin
      if (if_data_en_out)   sb_check(0, if_data_out);
      if (lbuf_data_en_out) sb_check(1, lbuf_data_out);
      if (st_done_out)      sb_check(2, 32'd0);
    end
  end

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: no response pulse within 100 cycles, expected one", name);
  endtask

  // Requester drivers: hold en and operands until the expected number of own pulses.
  task automatic req_load(input logic [31:0] a, input logic [`INST_TYPE_WIDTH-1:0] t,
                          input int cnt);
    int seen = 0;
    int budget = 0;
    lbuf_en_in = 1'b1;
    lbuf_A_in = a;
    lbuf_inst_type_in = t;
    while (seen < cnt && budget < 100) begin
      @(negedge clk);
      #1;
      budget++;
      if (lbuf_data_en_out) seen++;
    end
    if (seen < cnt) timeout("load_timeout");
    lbuf_en_in = 1'b0;
  endtask

  task automatic req_fetch(input logic [31:0] a);
    int seen = 0;
    int budget = 0;
    if_en_in = 1'b1;
    if_addr_in = a;
    while (seen < 1 && budget < 100) begin
      @(negedge clk);
      #1;
      budget++;
      if (if_data_en_out) seen++;
    end
    if (seen < 1) timeout("fetch_timeout");
    if_en_in = 1'b0;
  endtask

  task automatic req_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [`INST_TYPE_WIDTH-1:0] t);
    int seen = 0;
    int budget = 0;
    st_en_in = 1'b1;
    st_addr_in = a;
    st_data_in = d;
    st_inst_type_in = t;
    while (seen < 1 && budget < 100) begin
      @(negedge clk);
      #1;
      budget++;
      if (st_done_out) seen++;
    end
    if (seen < 1) timeout("store_timeout");
    st_en_in = 1'b0;
  endtask

  initial begin
    int w;
    rst_in = 1'b1;
    rdy_in = 1'b1;
    rob_flush_in = 1'b0;
    lbuf_dest_in = '0;
    // Requests active throughout reset must not be granted.
    if_en_in = 1'b1;
    if_addr_in = 32'h0;
    lbuf_en_in = 1'b1;
    lbuf_A_in = 32'h100;
    lbuf_inst_type_in = `LB;
    st_en_in = 1'b1;
    st_addr_in = 32'h200;
    st_data_in = 32'hDEADBEEF;
    st_inst_type_in = `SW;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_pulses", {28'd0, if_data_en_out, lbuf_data_en_out, st_done_out, mem_wr_out},
          32'd0);
      chk("rst_mem_a", mem_a_out, 32'd0);
      chk("rst_data", if_data_out | lbuf_data_out | {24'd0, mem_dout_out}, 32'd0);
    end
    rst_in = 1'b0;
    if_en_in = 1'b0;
    lbuf_en_in = 1'b0;
    st_en_in = 1'b0;
    @(negedge clk);
    chk("idle_rdy", {29'd0, if_rdy_out, lbuf_rdy_out, st_rdy_out}, 32'h7);
    chk("idle_mem_a", mem_a_out, 32'd0);

    // Sign/zero extension for byte and halfword loads.
    @(negedge clk); expect_rsp(1, 32'hFFFFFF80, cyc + 3); req_load(32'h100, `LB, 1);
    @(negedge clk); expect_rsp(1, 32'h00000080, cyc + 3); req_load(32'h100, `LBU, 1);
    @(negedge clk); expect_rsp(1, 32'hFFFFF080, cyc + 4); req_load(32'h100, `LH, 1);
    @(negedge clk); expect_rsp(1, 32'h0000F080, cyc + 4); req_load(32'h100, `LHU, 1);
    // Address wraps from 0xFFFFFFFF to 0x00000000.
    @(negedge clk); expect_rsp(1, 32'h0000135A, cyc + 4); req_load(32'hFFFFFFFF, `LH, 1);

    // Store beats fetch; fetch follows after one IDLE cycle.
    @(negedge clk);
    expect_rsp(2, 32'd0, cyc + 5);
    expect_rsp(0, 32'h00100513, cyc + 12);
    fork
      req_store(32'h200, 32'hDEADBEEF, `SW);
      req_fetch(32'h0);
    join
    chk("sw_byte0", {24'd0, ram[10'h200]}, 32'hEF);
    chk("sw_byte1", {24'd0, ram[10'h201]}, 32'hBE);
    chk("sw_byte2", {24'd0, ram[10'h202]}, 32'hAD);
    chk("sw_byte3", {24'd0, ram[10'h203]}, 32'hDE);

    // Byte store writes one byte only, then reads back.
    @(negedge clk); expect_rsp(2, 32'd0, cyc + 2); req_store(32'h240, 32'hFFFFFFAB, `SB);
    chk("sb_byte0", {24'd0, ram[10'h240]}, 32'hAB);
    chk("sb_byte1", {24'd0, ram[10'h241]}, 32'h00);
    @(negedge clk); expect_rsp(1, 32'hFFFFFFAB, cyc + 3); req_load(32'h240, `LB, 1);

    // Flush on cycle 2 of an LW: no response, IDLE on cycle 3.
    @(negedge clk);
    lbuf_en_in = 1'b1;
    lbuf_A_in = 32'h300;
    lbuf_inst_type_in = `LW;
    repeat (2) @(negedge clk);
    rob_flush_in = 1'b1;
    @(negedge clk);
    #1;
    chk("flush_idle", {31'd0, lbuf_rdy_out}, 32'd1);
    rob_flush_in = 1'b0;
    lbuf_en_in = 1'b0;
    repeat (8) @(negedge clk);
    expect_rsp(1, 32'h00000080, cyc + 3); req_load(32'h100, `LBU, 1);

    // Flush during a halfword store is ignored.
    @(negedge clk);
    expect_rsp(2, 32'd0, cyc + 3);
    fork
      req_store(32'h250, 32'h1234CAFE, `SH);
      begin
        @(negedge clk);
        rob_flush_in = 1'b1;
        repeat (2) @(negedge clk);
        rob_flush_in = 1'b0;
      end
    join
    chk("sh_byte0", {24'd0, ram[10'h250]}, 32'hFE);
    chk("sh_byte1", {24'd0, ram[10'h251]}, 32'hCA);
    chk("sh_byte2", {24'd0, ram[10'h252]}, 32'h00);

    // rdy_in low for 3 cycles mid-LW: address holds, no writes, result 3 cycles late.
    @(negedge clk);
    expect_rsp(1, 32'h44332211, cyc + 9);
    fork
      req_load(32'h300, `LW, 1);
      begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          rdy_in = 1'b0;
          #1;
          chk($sformatf("stall_mem_a%0d", i), mem_a_out, 32'h301);
          chk($sformatf("stall_wr%0d", i), {31'd0, mem_wr_out}, 32'd0);
          @(negedge clk);
        end
        rdy_in = 1'b1;
      end
    join

    // Load and fetch held together; load gets two requests.
    @(negedge clk);
`ifdef MEM_ARB_RR_EN
    expect_rsp(1, 32'hFFFFFF80, cyc + 3);
    expect_rsp(0, 32'h00100513, cyc + 10);
    expect_rsp(1, 32'hFFFFFF80, cyc + 14);
`else
    expect_rsp(1, 32'hFFFFFF80, cyc + 3);
    expect_rsp(1, 32'hFFFFFF80, cyc + 7);
    expect_rsp(0, 32'h00100513, cyc + 14);
`endif
    fork
      req_load(32'h100, `LB, 2);
      req_fetch(32'h0);
    join

    w = 0;
    while (sb_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
